denoise_frame_align: RTL

//  Upstream stage of the denoise core. Takes the previous-frame stream (VDMA readback) and the current-frame stream (sensor).

---
 rtl/denoise_frame_align_pkg.sv | 18 +
 rtl/denoise_frame_align_axis_out_reg.sv | 46 ++++
 rtl/denoise_frame_align.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/denoise_frame_align_pkg.sv
// Shared definitions for the denoise front end: alignment FSM encoding and
// the width of one registered AXIS beat (pixel plus tlast/tuser sideband).
package denoise_pkg;

    typedef enum logic {
        ALIGN_SEEK = 1'b0,
        ALIGN_RUN  = 1'b1
    } align_state_e;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int AXIS_SIDEBAND_W    = 2;
    localparam int AXIS_BEAT_W        = DEFAULT_DATA_WIDTH + AXIS_SIDEBAND_W;

    function automatic int axis_beat_w(input int data_width);
        return data_width + AXIS_SIDEBAND_W;
    endfunction

endpackage

// File: rtl/denoise_frame_align_axis_out_reg.sv
// One-entry registered AXIS output slot. tvalid comes straight from a flop,
// so it never depends combinationally on tready.
module axis_out_reg
    import denoise_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] beat_data,
    input  logic                  beat_last,
    input  logic                  beat_user,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  free
);

    localparam int BEAT_W = axis_beat_w(DATA_WIDTH);

    logic [BEAT_W-1:0] beat_q;
    logic              valid_q;

    // The owner only asserts load when free is set, so a load always wins.
    always_ff @(posedge aclk) begin
        if (areset) begin
            valid_q <= 1'b0;
            beat_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            beat_q  <= {beat_user, beat_last, beat_data};
        end else if (m_axis_tready) begin
            valid_q <= 1'b0;
        end
    end

    assign m_axis_tdata  = beat_q[DATA_WIDTH-1:0];
    assign m_axis_tlast  = beat_q[DATA_WIDTH];
    assign m_axis_tuser  = beat_q[DATA_WIDTH+1];
    assign m_axis_tvalid = valid_q;
    assign free          = !valid_q || m_axis_tready;

endmodule

// File: rtl/denoise_frame_align.sv
// Aligns the previous-frame and current-frame AXIS streams on start-of-frame
// and forwards them strictly pairwise so pixel i of prev meets pixel i of curr.
module denoise_frame_align
    import denoise_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  sw_resync,

    input  logic [DATA_WIDTH-1:0] s_prev_axis_tdata,
    input  logic                  s_prev_axis_tvalid,
    output logic                  s_prev_axis_tready,
    input  logic                  s_prev_axis_tlast,
    input  logic                  s_prev_axis_tuser,

    input  logic [DATA_WIDTH-1:0] s_curr_axis_tdata,
    input  logic                  s_curr_axis_tvalid,
    output logic                  s_curr_axis_tready,
    input  logic                  s_curr_axis_tlast,
    input  logic                  s_curr_axis_tuser,

    output logic [DATA_WIDTH-1:0] m_prev_axis_tdata,
    output logic                  m_prev_axis_tvalid,
    input  logic                  m_prev_axis_tready,
    output logic                  m_prev_axis_tlast,
    output logic                  m_prev_axis_tuser,

    output logic [DATA_WIDTH-1:0] m_curr_axis_tdata,
    output logic                  m_curr_axis_tvalid,
    input  logic                  m_curr_axis_tready,
    output logic                  m_curr_axis_tlast,
    output logic                  m_curr_axis_tuser,

    output logic                  locked,
    output logic [CNT_WIDTH-1:0]  resync_count,
    output logic [CNT_WIDTH-1:0]  drop_prev_count,
    output logic [CNT_WIDTH-1:0]  drop_curr_count
);

    // Handshake: on every port a beat transfers on the rising aclk edge where
    // tvalid and tready are both 1; tvalid/tdata/tlast/tuser stay stable while
    // tvalid=1 and tready=0, and tvalid never waits on tready.

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    align_state_e state_q;
    align_state_e state_d;

    logic prev_free;
    logic curr_free;
    logic slot_free;
    logic prev_at_sof;
    logic curr_at_sof;
    logic pair;
    logic heads_match;
    logic load_pair;
    logic drop_prev;
    logic drop_curr;
    logic mismatch;

    assign slot_free   = prev_free && curr_free;
    assign pair        = s_prev_axis_tvalid && s_curr_axis_tvalid && slot_free;
    assign heads_match = (s_prev_axis_tuser == s_curr_axis_tuser) &&
                         (s_prev_axis_tlast == s_curr_axis_tlast);
    assign prev_at_sof = s_prev_axis_tvalid && s_prev_axis_tuser;
    assign curr_at_sof = s_curr_axis_tvalid && s_curr_axis_tuser;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= ALIGN_SEEK;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        s_prev_axis_tready = 1'b0;
        s_curr_axis_tready = 1'b0;
        load_pair          = 1'b0;
        drop_prev          = 1'b0;
        drop_curr          = 1'b0;
        mismatch           = 1'b0;
        case (state_q)
            ALIGN_SEEK: begin
                // Non-SOF heads are discarded; an SOF head is held until its partner arrives.
                drop_prev          = s_prev_axis_tvalid && !s_prev_axis_tuser;
                drop_curr          = s_curr_axis_tvalid && !s_curr_axis_tuser;
                s_prev_axis_tready = drop_prev;
                s_curr_axis_tready = drop_curr;
                if (prev_at_sof && curr_at_sof && !sw_resync) begin
                    state_d = ALIGN_RUN;
                end
            end
            ALIGN_RUN: begin
                load_pair          = pair && heads_match && !sw_resync;
                mismatch           = pair && !heads_match;
                s_prev_axis_tready = load_pair;
                s_curr_axis_tready = load_pair;
                if (mismatch || sw_resync) begin
                    state_d = ALIGN_SEEK;
                end
            end
            default: state_d = ALIGN_SEEK;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            resync_count    <= '0;
            drop_prev_count <= '0;
            drop_curr_count <= '0;
        end else begin
            if (mismatch && resync_count != CNT_MAX) begin
                resync_count <= resync_count + CNT_ONE;
            end
            if (drop_prev && drop_prev_count != CNT_MAX) begin
                drop_prev_count <= drop_prev_count + CNT_ONE;
            end
            if (drop_curr && drop_curr_count != CNT_MAX) begin
                drop_curr_count <= drop_curr_count + CNT_ONE;
            end
        end
    end

    assign locked = (state_q == ALIGN_RUN);

    axis_out_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_prev_out (
        .aclk          (aclk),
        .areset        (areset),
        .load          (load_pair),
        .beat_data     (s_prev_axis_tdata),
        .beat_last     (s_prev_axis_tlast),
        .beat_user     (s_prev_axis_tuser),
        .m_axis_tdata  (m_prev_axis_tdata),
        .m_axis_tvalid (m_prev_axis_tvalid),
        .m_axis_tready (m_prev_axis_tready),
        .m_axis_tlast  (m_prev_axis_tlast),
        .m_axis_tuser  (m_prev_axis_tuser),
        .free          (prev_free)
    );

    axis_out_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_curr_out (
        .aclk          (aclk),
        .areset        (areset),
        .load          (load_pair),
        .beat_data     (s_curr_axis_tdata),
        .beat_last     (s_curr_axis_tlast),
        .beat_user     (s_curr_axis_tuser),
        .m_axis_tdata  (m_curr_axis_tdata),
        .m_axis_tvalid (m_curr_axis_tvalid),
        .m_axis_tready (m_curr_axis_tready),
        .m_axis_tlast  (m_curr_axis_tlast),
        .m_axis_tuser  (m_curr_axis_tuser),
        .free          (curr_free)
    );

endmodule
